// File: rtl/uart_tx_byte_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_byte_engine                                              |
// | Purpose : Holds a 32-bit result word, picks one of its bytes on command    |
// |           and sends it as a single UART 8N1 frame (start, 8 data bits LSB  |
// |           first, stop). tx_busy tells the upstream controller when the     |
// |           next byte may be requested.                                      |
// | Ports   : clk               - system clock, rising edge                    |
// |           reset             - asynchronous, active-low reset               |
// |           result32          - result word to hold                          |
// |           register_result32 - level; load result32 into the hold register |
// |           send_b0..send_b3  - byte select for the next frame (b0 wins)     |
// |           tx_start          - 1-cycle pulse; start a frame                 |
// |           tx_busy           - high while a frame is in progress            |
// |           tx_serial         - UART TX line, idle high                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx_byte_engine #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result32,
  input  logic        register_result32,
  input  logic        send_b0,
  input  logic        send_b1,
  input  logic        send_b2,
  input  logic        send_b3,
  input  logic        tx_start,
  output logic        tx_busy,
  output logic        tx_serial
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int c_CNT_W        = (c_CLKS_PER_BIT > 2) ? $clog2(c_CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);

  generate
    if (c_CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_byte_engine: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_baud_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic [31:0]          r_hold;
  logic                 r_tx_serial;
  logic                 r_tx_busy;

  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   w_baud_nxt;
  logic [2:0]           w_bit_nxt;
  logic [7:0]           w_shift_nxt;
  logic                 w_serial_nxt;
  logic                 w_busy_nxt;
  logic                 w_baud_wrap;
  logic                 w_any_sel;
  logic [7:0]           w_sel_byte;

  assign tx_busy     = r_tx_busy;
  assign tx_serial   = r_tx_serial;
  assign w_baud_wrap = (r_baud_cnt == c_BAUD_LAST);
  assign w_any_sel   = send_b0 | send_b1 | send_b2 | send_b3;

  // Lowest-numbered select wins when several are high.
  always_comb begin
    w_sel_byte = r_hold[31:24];
    if (send_b0)      w_sel_byte = r_hold[7:0];
    else if (send_b1) w_sel_byte = r_hold[15:8];
    else if (send_b2) w_sel_byte = r_hold[23:16];
  end

  // Hold register reloads independently of the frame; the frame works from
  // its own copy in r_shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
    end else if (register_result32) begin
      r_hold <= result32;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx_serial <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud_cnt  <= w_baud_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_tx_serial <= w_serial_nxt;
      r_tx_busy   <= w_busy_nxt;
    end
  end

  // The line level is computed one cycle ahead so that tx_serial comes
  // straight from a flop: each branch sets the level for the coming bit.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = w_baud_wrap ? '0 : (r_baud_cnt + c_BAUD_ONE);
    w_bit_nxt    = r_bit_idx;
    w_shift_nxt  = r_shift;
    w_serial_nxt = r_tx_serial;
    w_busy_nxt   = r_tx_busy;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt   = '0;
        w_serial_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
        if (tx_start && w_any_sel) begin
          w_shift_nxt  = w_sel_byte;
          w_state_nxt  = S_START;
          w_busy_nxt   = 1'b1;
          w_serial_nxt = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_wrap) begin
          w_state_nxt  = S_DATA;
          w_bit_nxt    = 3'd0;
          w_serial_nxt = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt  = S_STOP;
            w_serial_nxt = 1'b1;
          end else begin
            w_bit_nxt    = r_bit_idx + 3'd1;
            w_shift_nxt  = r_shift >> 1;
            w_serial_nxt = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_baud_wrap) begin
          w_state_nxt  = S_IDLE;
          w_busy_nxt   = 1'b0;
          w_serial_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_baud_nxt   = '0;
        w_serial_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_byte_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_tx_byte_engine                                           |
// | Purpose : Self-checking bench for uart_tx_byte_engine. A reference model   |
// |           expands each accepted frame into its expected line waveform and  |
// |           every cycle's tx_serial / tx_busy is compared against it.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_tx_byte_engine;

  localparam int c_CLK_FREQ = 16;
  localparam int c_BAUD     = 1;
  localparam int c_CPB      = 16;
  localparam int c_FRAME    = 10 * c_CPB;

  logic        clk;
  logic        reset;
  logic [31:0] result32;
  logic        register_result32;
  logic        send_b0, send_b1, send_b2, send_b3;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_serial;

  uart_tx_byte_engine #(
    .CLK_FREQ (c_CLK_FREQ),
    .BAUD_RATE(c_BAUD)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .result32         (result32),
    .register_result32(register_result32),
    .send_b0          (send_b0),
    .send_b1          (send_b1),
    .send_b2          (send_b2),
    .send_b3          (send_b3),
    .tx_start         (tx_start),
    .tx_busy          (tx_busy),
    .tx_serial        (tx_serial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: the hold word and the queue of line levels still owed
  // for the current frame (empty queue = idle).
  logic [31:0] m_hold;
  logic        m_line_q[$];
  logic        samples[0:c_FRAME-1];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [3:0] sel);
    if (sel[0])      return w[7:0];
    else if (sel[1]) return w[15:8];
    else if (sel[2]) return w[23:16];
    else             return w[31:24];
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    logic [31:0] hold_old;
    logic [3:0]  sel;
    logic [7:0]  b;
    hold_old = m_hold;
    sel      = {send_b3, send_b2, send_b1, send_b0};
    if (!reset) begin
      m_hold = '0;
      m_line_q.delete();
      return;
    end
    if (register_result32) m_hold = result32;
    if (m_line_q.size() != 0) begin
      void'(m_line_q.pop_front());
    end else if (tx_start && (sel != 4'b0)) begin
      b = pick_byte(hold_old, sel);
      for (int i = 0; i < c_CPB; i++) m_line_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < c_CPB; i++) m_line_q.push_back(b[k]);
      for (int i = 0; i < c_CPB; i++) m_line_q.push_back(1'b1);
    end
  endtask

  task automatic step();
    logic exp_line;
    model_edge();
    @(posedge clk);
    #1;
    exp_line = (m_line_q.size() != 0) ? m_line_q[0] : 1'b1;
    check_value("line", {31'b0, tx_serial}, {31'b0, exp_line});
    check_value("busy", {31'b0, tx_busy}, {31'b0, (m_line_q.size() != 0)});
  endtask

  task automatic clear_inputs();
    send_b0 = 1'b0; send_b1 = 1'b0; send_b2 = 1'b0; send_b3 = 1'b0;
    tx_start = 1'b0;
    register_result32 = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    result32 = w;
    register_result32 = 1'b1;
    step();
    register_result32 = 1'b0;
  endtask

  // Start a frame, follow it to the end, then decode it from mid-bit samples.
  // action 1: spurious tx_start+send_b1 at cycle inject_at;
  // action 2: reload hold with all-ones at cycle inject_at.
  task automatic start_and_measure(input logic [3:0] sel, input int inject_at,
                                   input int action, input logic [7:0] exp_byte,
                                   output int busy_cycles);
    logic [7:0] got;
    {send_b3, send_b2, send_b1, send_b0} = sel;
    tx_start = 1'b1;
    step();
    clear_inputs();
    busy_cycles = 0;
    while (tx_busy === 1'b1 && busy_cycles < 400) begin
      if (busy_cycles < c_FRAME) samples[busy_cycles] = tx_serial;
      if (busy_cycles == inject_at) begin
        if (action == 1) begin
          tx_start = 1'b1;
          send_b1  = 1'b1;
        end else if (action == 2) begin
          result32 = 32'hFFFF_FFFF;
          register_result32 = 1'b1;
        end
      end
      busy_cycles++;
      step();
      clear_inputs();
    end
    check_value("busy_len", busy_cycles, c_FRAME);
    for (int k = 0; k < 8; k++) got[k] = samples[c_CPB * (k + 1) + c_CPB / 2];
    check_value("start_bit", {31'b0, samples[c_CPB / 2]}, 32'd0);
    check_value("data_byte", {24'b0, got}, {24'b0, exp_byte});
    check_value("stop_bit", {31'b0, samples[9 * c_CPB + c_CPB / 2]}, 32'd1);
  endtask

  initial begin
    int bc;
    int total;
    logic [7:0] exp_b[4];

    reset    = 1'b0;
    result32 = '0;
    m_hold   = '0;
    clear_inputs();

    // Reset state
    repeat (3) step();
    check_value("rst_serial", {31'b0, tx_serial}, 32'd1);
    check_value("rst_busy", {31'b0, tx_busy}, 32'd0);
    reset = 1'b1;
    step();

    // Byte 0 of the reference word, then each other byte and priority cases
    load_word(32'hA5C3_3C5A);
    start_and_measure(4'b0001, -1, 0, 8'h5A, bc);
    start_and_measure(4'b1000, -1, 0, 8'hA5, bc);
    start_and_measure(4'b0010, -1, 0, 8'h3C, bc);
    start_and_measure(4'b0100, -1, 0, 8'hC3, bc);
    start_and_measure(4'b0110, -1, 0, 8'h3C, bc);
    start_and_measure(4'b1100, -1, 0, 8'hC3, bc);
    start_and_measure(4'b1111, -1, 0, 8'h5A, bc);

    // tx_start without a select is ignored
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check_value("nosel_ignored", {31'b0, tx_busy}, 32'd0);
    step();

    // tx_start during a frame is ignored and not queued
    start_and_measure(4'b0001, 50, 1, 8'h5A, bc);
    repeat (20) step();
    check_value("no_second_frame", {31'b0, tx_busy}, 32'd0);

    // Hold reload mid-frame only affects the next frame
    start_and_measure(4'b0001, 60, 2, 8'h5A, bc);
    start_and_measure(4'b0001, -1, 0, 8'hFF, bc);

    // Asynchronous reset in the middle of a frame
    load_word(32'hA5C3_3C5A);
    send_b0  = 1'b1;
    tx_start = 1'b1;
    step();
    clear_inputs();
    repeat (69) step();
    #2 reset = 1'b0;
    #1;
    check_value("async_rst_serial", {31'b0, tx_serial}, 32'd1);
    check_value("async_rst_busy", {31'b0, tx_busy}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    start_and_measure(4'b0001, -1, 0, 8'h00, bc);

    // Controller-style back-to-back sequence over all four bytes
    load_word(32'h1234_5678);
    exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      start_and_measure(4'(1 << i), -1, 0, exp_b[i], bc);
      total += bc;
    end
    check_value("seq_busy_total", total, 4 * c_FRAME);

    // Randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 6000; n++) begin
      reset             = ($urandom_range(0, 1499) != 0);
      register_result32 = ($urandom_range(0, 15) == 0);
      result32          = $urandom;
      if ($urandom_range(0, 2) == 0)
        {send_b3, send_b2, send_b1, send_b0} = 4'b0000;
      else
        {send_b3, send_b2, send_b1, send_b0} = 4'($urandom_range(0, 15));
      tx_start = ($urandom_range(0, 7) == 0);
      step();
    end
    reset = 1'b1;
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
